// File: rtl/axi_dma_pkg.sv
// Shared types and constants for the DMA burst splitter: the 1D request and
// chunk structs, the FSM state type, the split boundary and a min3 helper.
package axi_dma_pkg;

    localparam int unsigned ADDR_W         = 48;
    localparam int unsigned DATA_W         = 64;
    localparam int unsigned BYTES_PER_BEAT = DATA_W / 8;
    localparam int unsigned BEATS_MAX      = 256;
    localparam int unsigned PAGE_BYTES     = 4096;
    localparam int unsigned ID_W           = 4;
    localparam int unsigned USER_W         = 4;

    // Largest chunk that can cross neither a page nor a max-length burst.
    localparam int unsigned BOUND = (PAGE_BYTES < BEATS_MAX * BYTES_PER_BEAT) ?
                                    PAGE_BYTES : BEATS_MAX * BYTES_PER_BEAT;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        addr_t             src;
        addr_t             dst;
        addr_t             num_bytes;
        logic [3:0]        src_cache;
        logic [3:0]        dst_cache;
        logic [1:0]        src_burst;
        logic [1:0]        dst_burst;
        logic [USER_W-1:0] src_user;
        logic [USER_W-1:0] dst_user;
        logic              decouple_rw;
        logic              deburst;
    } burst_req_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        addr_t             src;
        addr_t             dst;
        addr_t             num_bytes;
        logic [3:0]        src_cache;
        logic [3:0]        dst_cache;
        logic [1:0]        src_burst;
        logic [1:0]        dst_burst;
        logic [USER_W-1:0] src_user;
        logic [USER_W-1:0] dst_user;
        logic              decouple_rw;
        logic              deburst;
    } chunk_t;

    // Splitter FSM state; busy_o mirrors state != IDLE.
    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    function automatic addr_t min3(input addr_t a, input addr_t b, input addr_t c);
        addr_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/axi_dma_boundary_calc.sv
// Combinational chunk length: distance to the next boundary on the source
// and destination side, clipped to the bytes still remaining.
module axi_dma_boundary_calc
    import axi_dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_W,
    parameter int unsigned BOUND_BYTES = BOUND,
    parameter int unsigned BEAT_BYTES  = BYTES_PER_BEAT
) (
    input  logic [ADDR_WIDTH-1:0] src_i,
    input  logic [ADDR_WIDTH-1:0] dst_i,
    input  logic [ADDR_WIDTH-1:0] rem_i,
    input  logic                  deburst_i,
    output logic [ADDR_WIDTH-1:0] len_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] bnd;
    logic [ADDR_WIDTH-1:0] lim_src;
    logic [ADDR_WIDTH-1:0] lim_dst;

    // Boundaries are powers of two, so "addr mod B" is a mask; limits land in 1..B.
    always_comb begin
        bnd     = deburst_i ? ADDR_WIDTH'(BEAT_BYTES) : ADDR_WIDTH'(BOUND_BYTES);
        lim_src = bnd - (src_i & (bnd - ADDR_WIDTH'(1)));
        lim_dst = bnd - (dst_i & (bnd - ADDR_WIDTH'(1)));
        len_o   = min3(rem_i, lim_src, lim_dst);
        last_o  = (len_o == rem_i);
    end

endmodule

// File: rtl/axi_dma_burst_splitter.sv
// Splits arbitrary-length 1D DMA requests into chunks that never cross a
// page or max-burst boundary on either side. One chunk per cycle; a new
// request may be taken in the same cycle the previous last chunk leaves.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and chunk fields stay stable while
// chunk_valid_o is high and chunk_ready_i is low.
module axi_dma_burst_splitter
    import axi_dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W,
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned MAX_BEATS  = BEATS_MAX,
    parameter int unsigned PAGE_SIZE  = PAGE_BYTES
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  burst_req_t burst_req_i,
    input  logic       burst_last_i,
    input  logic       burst_req_valid_i,
    output logic       burst_req_ready_o,
    output chunk_t     chunk_o,
    output logic       chunk_last_o,
    output logic       chunk_twod_last_o,
    output logic       chunk_valid_o,
    input  logic       chunk_ready_i,
    output logic       busy_o
);

    localparam int unsigned BYTES       = DATA_WIDTH / 8;
    localparam int unsigned SPLIT_BOUND = (PAGE_SIZE < MAX_BEATS * BYTES) ?
                                          PAGE_SIZE : MAX_BEATS * BYTES;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ADDR_WIDTH-1:0] rem_q, rem_d;
    burst_req_t            req_q, req_d;
    logic                  twod_q, twod_d;

    logic [ADDR_WIDTH-1:0] cur_len;
    logic                  cur_last;
    logic                  in_split;
    logic                  chunk_hs;
    logic                  req_hs;

    axi_dma_boundary_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BOUND_BYTES(SPLIT_BOUND),
        .BEAT_BYTES (BYTES)
    ) u_calc (
        .src_i    (src_q),
        .dst_i    (dst_q),
        .rem_i    (rem_q),
        .deburst_i(req_q.deburst),
        .len_o    (cur_len),
        .last_o   (cur_last)
    );

    assign in_split          = (state_q == SPLIT);
    assign chunk_hs          = in_split & chunk_ready_i;
    // Ready also while the final chunk leaves, giving zero-bubble back-to-back.
    assign burst_req_ready_o = (state_q == IDLE) | (chunk_hs & cur_last);
    assign req_hs            = burst_req_valid_i & burst_req_ready_o;
    assign chunk_valid_o     = in_split;
    assign chunk_last_o      = in_split & cur_last;
    assign chunk_twod_last_o = chunk_last_o & twod_q;
    assign busy_o            = in_split;

    // Chunk fields come only from registers; zero when idle.
    always_comb begin
        chunk_o = '0;
        if (in_split) begin
            chunk_o.id          = req_q.id;
            chunk_o.src         = src_q;
            chunk_o.dst         = dst_q;
            chunk_o.num_bytes   = cur_len;
            chunk_o.src_cache   = req_q.src_cache;
            chunk_o.dst_cache   = req_q.dst_cache;
            chunk_o.src_burst   = req_q.src_burst;
            chunk_o.dst_burst   = req_q.dst_burst;
            chunk_o.src_user    = req_q.src_user;
            chunk_o.dst_user    = req_q.dst_user;
            chunk_o.decouple_rw = req_q.decouple_rw;
            chunk_o.deburst     = req_q.deburst;
        end
    end

    // Next state: advance cursors per chunk, then let a new request override.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        req_d   = req_q;
        twod_d  = twod_q;
        if (chunk_hs) begin
            src_d = src_q + cur_len;
            dst_d = dst_q + cur_len;
            rem_d = rem_q - cur_len;
            if (cur_last) begin
                state_d = IDLE;
            end
        end
        // A zero-length request is consumed without producing a chunk.
        if (req_hs && (burst_req_i.num_bytes != '0)) begin
            state_d = SPLIT;
            src_d   = burst_req_i.src;
            dst_d   = burst_req_i.dst;
            rem_d   = burst_req_i.num_bytes;
            req_d   = burst_req_i;
            twod_d  = burst_last_i;
        end
    end

    // State and cursor registers; reset drops any in-flight request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            req_q   <= '0;
            twod_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            req_q   <= req_d;
            twod_q  <= twod_d;
        end
    end

endmodule
